// File: rtl/sram_readback_checker_if.sv
// Signal bundle between the SRAM readback harness and sram_readback_checker.
// Defining ERR_LOG_EN adds the failing-address log pop/head signals.
interface sram_readback_checker_if #(
    parameter int ADDR_W = 13,
    parameter int ERR_W  = 16
);
    logic              START;
    logic [1:0]        MODE;
    logic              DVALID;
    logic              DDOUT;
    logic              BUSY;
    logic              DONE;
    logic              PASS;
    logic [ERR_W-1:0]  ERRCNT;
    logic              FIRST_ERR_VLD;
    logic [ADDR_W-1:0] FIRST_ERR_ADDR;
    logic [ADDR_W-1:0] WORD_ADDR;
`ifdef ERR_LOG_EN
    logic              ERRLOG_POP;
    logic              ERRLOG_VLD;
    logic [ADDR_W-1:0] ERRLOG_ADDR;

    modport master (
        output START, MODE, DVALID, DDOUT, ERRLOG_POP,
        input  BUSY, DONE, PASS, ERRCNT, FIRST_ERR_VLD, FIRST_ERR_ADDR, WORD_ADDR,
               ERRLOG_VLD, ERRLOG_ADDR
    );
    modport slave (
        input  START, MODE, DVALID, DDOUT, ERRLOG_POP,
        output BUSY, DONE, PASS, ERRCNT, FIRST_ERR_VLD, FIRST_ERR_ADDR, WORD_ADDR,
               ERRLOG_VLD, ERRLOG_ADDR
    );
`else
    modport master (
        output START, MODE, DVALID, DDOUT,
        input  BUSY, DONE, PASS, ERRCNT, FIRST_ERR_VLD, FIRST_ERR_ADDR, WORD_ADDR
    );
    modport slave (
        input  START, MODE, DVALID, DDOUT,
        output BUSY, DONE, PASS, ERRCNT, FIRST_ERR_VLD, FIRST_ERR_ADDR, WORD_ADDR
    );
`endif
endinterface

// File: rtl/sram_readback_checker.sv
// Packs the serial SRAM readback stream into words and checks them against a
// generated pattern. ERR_LOG_EN adds a 4-entry log of failing addresses.
//
// state  | meaning
// S_IDLE | out of reset, no pass started
// S_RUN  | pass in progress, accepting readback bits
// S_DONE | last word compared, results held until next START
module sram_readback_checker #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 13,
    parameter int NWORDS = 8192,
    parameter int ERR_W  = 16
) (
    input logic                    sysclk,
    input logic                    RST,
    sram_readback_checker_if.slave bus
);
    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NWORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state_q, state_d;

    logic [1:0]        mode_q;
    logic [WORD_W-1:0] shift_q, shift_next, cmp_word_q, expected;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [ADDR_W-1:0] word_addr_q, cmp_addr_q, first_err_addr_q;
    logic              cmp_vld_q, cmp_last_q, first_err_vld_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic              mismatch, bit_take, word_end;

    // Once the last word is captured, trailing bits must not start a new word.
    assign bit_take   = (state_q == S_RUN) && !bus.START && bus.DVALID
                        && !(cmp_vld_q && cmp_last_q);
    assign word_end   = bit_take && (bit_cnt_q == LAST_BIT);
    assign shift_next = WORD_W'({shift_q, bus.DDOUT});
    assign mismatch   = cmp_vld_q && (cmp_word_q != expected);

    always_comb begin
        expected = '0;
        unique case (mode_q)
            2'b00: expected = '0;
            2'b01: expected = '1;
            2'b10: begin
                for (int i = 0; i < WORD_W; i++)
                    expected[i] = ((i % 2) == 1) ^ cmp_addr_q[0];
            end
            default: expected = WORD_W'(cmp_addr_q);
        endcase
    end

    always_ff @(posedge sysclk or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.START) state_d = S_RUN;
            S_RUN: begin
                if (bus.START)                   state_d = S_RUN;
                else if (cmp_vld_q && cmp_last_q) state_d = S_DONE;
            end
            S_DONE: if (bus.START) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge RST) begin
        if (!RST) begin
            mode_q           <= '0;
            shift_q          <= '0;
            bit_cnt_q        <= '0;
            word_addr_q      <= '0;
            cmp_word_q       <= '0;
            cmp_addr_q       <= '0;
            cmp_vld_q        <= 1'b0;
            cmp_last_q       <= 1'b0;
            err_cnt_q        <= '0;
            first_err_vld_q  <= 1'b0;
            first_err_addr_q <= '0;
        end else if (bus.START) begin
            mode_q           <= bus.MODE;
            shift_q          <= '0;
            bit_cnt_q        <= '0;
            word_addr_q      <= '0;
            cmp_vld_q        <= 1'b0;
            cmp_last_q       <= 1'b0;
            err_cnt_q        <= '0;
            first_err_vld_q  <= 1'b0;
            first_err_addr_q <= '0;
        end else begin
            cmp_vld_q <= word_end;
            if (bit_take) shift_q <= shift_next;
            if (word_end) begin
                cmp_word_q <= shift_next;
                cmp_addr_q <= word_addr_q;
                cmp_last_q <= (word_addr_q == LAST_ADDR);
                bit_cnt_q  <= '0;
                // Hold at the last address so the count never wraps within a pass.
                if (word_addr_q != LAST_ADDR) word_addr_q <= word_addr_q + 1'b1;
            end else if (bit_take) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (mismatch) begin
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
                if (!first_err_vld_q) begin
                    first_err_vld_q  <= 1'b1;
                    first_err_addr_q <= cmp_addr_q;
                end
            end
        end
    end

    assign bus.BUSY           = (state_q == S_RUN);
    assign bus.DONE           = (state_q == S_DONE);
    assign bus.PASS           = (state_q == S_DONE) && (err_cnt_q == '0);
    assign bus.ERRCNT         = err_cnt_q;
    assign bus.FIRST_ERR_VLD  = first_err_vld_q;
    assign bus.FIRST_ERR_ADDR = first_err_addr_q;
    assign bus.WORD_ADDR      = word_addr_q;

`ifdef ERR_LOG_EN
    logic [ADDR_W-1:0] log_mem [4];
    logic [1:0]        log_rd_q, log_wr_q;
    logic [2:0]        log_cnt_q;
    logic              log_push, log_pop;

    // A full log drops new entries even if the head is popped in the same cycle.
    assign log_push = mismatch && (log_cnt_q != 3'd4);
    assign log_pop  = bus.ERRLOG_POP && (log_cnt_q != 3'd0);

    always_ff @(posedge sysclk or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 4; i++) log_mem[i] <= '0;
            log_rd_q  <= '0;
            log_wr_q  <= '0;
            log_cnt_q <= '0;
        end else if (bus.START) begin
            log_rd_q  <= '0;
            log_wr_q  <= '0;
            log_cnt_q <= '0;
        end else begin
            if (log_push) begin
                log_mem[log_wr_q] <= cmp_addr_q;
                log_wr_q          <= log_wr_q + 1'b1;
            end
            if (log_pop) log_rd_q <= log_rd_q + 1'b1;
            unique case ({log_push, log_pop})
                2'b10:   log_cnt_q <= log_cnt_q + 3'd1;
                2'b01:   log_cnt_q <= log_cnt_q - 3'd1;
                default: log_cnt_q <= log_cnt_q;
            endcase
        end
    end

    assign bus.ERRLOG_VLD  = (log_cnt_q != 3'd0);
    assign bus.ERRLOG_ADDR = log_mem[log_rd_q];
`endif
endmodule

// File: tb/tb_sram_readback_checker.sv
// Bench for sram_readback_checker: two instances (NWORDS=4/ERR_W=16 and
// NWORDS=6/ERR_W=2) share one stimulus stream and are compared every cycle.
module tb_sram_readback_checker;
    logic sysclk = 1'b0;
    logic rst_n;
    logic start, dvalid, ddout, pop;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sysclk = ~sysclk;

    sram_readback_checker_if #(.ADDR_W(13), .ERR_W(16)) bus0 ();
    sram_readback_checker_if #(.ADDR_W(13), .ERR_W(2))  bus1 ();

    assign bus0.START = start;  assign bus1.START = start;
    assign bus0.MODE  = mode;   assign bus1.MODE  = mode;
    assign bus0.DVALID = dvalid; assign bus1.DVALID = dvalid;
    assign bus0.DDOUT = ddout;  assign bus1.DDOUT = ddout;
`ifdef ERR_LOG_EN
    assign bus0.ERRLOG_POP = pop; assign bus1.ERRLOG_POP = pop;
`endif

    sram_readback_checker #(.WORD_W(16), .ADDR_W(13), .NWORDS(4), .ERR_W(16)) dut0 (
        .sysclk(sysclk), .RST(rst_n), .bus(bus0));
    sram_readback_checker #(.WORD_W(16), .ADDR_W(13), .NWORDS(6), .ERR_W(2)) dut1 (
        .sysclk(sysclk), .RST(rst_n), .bus(bus1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nw(input int k);   return (k == 0) ? 4 : 6;      endfunction
    function automatic int emax(input int k); return (k == 0) ? 65535 : 3;  endfunction
    function automatic int exp_word(input int md, input int a);
        case (md)
            0:       return 0;
            1:       return 'hFFFF;
            2:       return (a % 2 == 0) ? 'hAAAA : 'h5555;
            default: return a & 'hFFFF;
        endcase
    endfunction

    int m_bits[2], m_cur[2], m_bad[2], m_first[2], m_mode[2], m_pend_addr[2], m_log_n[2];
    int m_log[2][4];
    bit m_active[2], m_done[2], m_pend[2], m_pend_bad[2], m_pend_last[2];

    task automatic model_clear(input int k);
        m_bits[k] = 0; m_cur[k] = 0; m_bad[k] = 0; m_first[k] = 0;
        m_pend[k] = 0; m_log_n[k] = 0;
    endtask

    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                model_clear(k);
                m_mode[k] = 0; m_active[k] = 0; m_done[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (start) begin
                    model_clear(k);
                    m_mode[k] = int'(mode); m_active[k] = 1; m_done[k] = 0;
                end else begin
                    int n_before;
                    n_before = m_log_n[k];
                    if (m_pend[k]) begin
                        if (m_pend_bad[k]) begin
                            if (m_bad[k] == 0) m_first[k] = m_pend_addr[k];
                            m_bad[k]++;
                            if (n_before < 4) begin
                                m_log[k][m_log_n[k]] = m_pend_addr[k];
                                m_log_n[k]++;
                            end
                        end
                        if (m_pend_last[k]) begin m_active[k] = 0; m_done[k] = 1; end
                        m_pend[k] = 0;
                    end
                    if (pop && n_before > 0) begin
                        for (int j = 0; j < 3; j++) m_log[k][j] = m_log[k][j+1];
                        m_log_n[k]--;
                    end
                    if (m_active[k] && dvalid && m_bits[k] < nw(k) * 16) begin
                        m_cur[k] = ((m_cur[k] << 1) | int'(ddout)) & 'hFFFF;
                        m_bits[k]++;
                        if (m_bits[k] % 16 == 0) begin
                            m_pend[k]      = 1;
                            m_pend_addr[k] = m_bits[k] / 16 - 1;
                            m_pend_bad[k]  = (m_cur[k] != exp_word(m_mode[k], m_pend_addr[k]));
                            m_pend_last[k] = (m_pend_addr[k] == nw(k) - 1);
                            m_cur[k]       = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic cmp_inst(input int k, input logic busy, done, pass,
                            input logic [31:0] errcnt, input logic fvld,
                            input logic [31:0] faddr, waddr,
                            input logic lvld, input logic [31:0] laddr);
        int e_err, e_wa;
        e_err = (m_bad[k] > emax(k)) ? emax(k) : m_bad[k];
        e_wa  = (m_bits[k] / 16 > nw(k) - 1) ? nw(k) - 1 : m_bits[k] / 16;
        check($sformatf("i%0d_busy", k), 32'(busy), 32'(m_active[k]));
        check($sformatf("i%0d_done", k), 32'(done), 32'(m_done[k]));
        check($sformatf("i%0d_pass", k), 32'(pass), 32'(m_done[k] && m_bad[k] == 0));
        check($sformatf("i%0d_errcnt", k), errcnt, e_err);
        check($sformatf("i%0d_first_vld", k), 32'(fvld), 32'(m_bad[k] > 0));
        check($sformatf("i%0d_first_addr", k), faddr, m_first[k]);
        check($sformatf("i%0d_word_addr", k), waddr, e_wa);
`ifdef ERR_LOG_EN
        check($sformatf("i%0d_log_vld", k), 32'(lvld), 32'(m_log_n[k] > 0));
        if (m_log_n[k] > 0) check($sformatf("i%0d_log_addr", k), laddr, m_log[k][0]);
`endif
    endtask

    always @(negedge sysclk) begin
`ifdef ERR_LOG_EN
        cmp_inst(0, bus0.BUSY, bus0.DONE, bus0.PASS, 32'(bus0.ERRCNT), bus0.FIRST_ERR_VLD,
                 32'(bus0.FIRST_ERR_ADDR), 32'(bus0.WORD_ADDR), bus0.ERRLOG_VLD, 32'(bus0.ERRLOG_ADDR));
        cmp_inst(1, bus1.BUSY, bus1.DONE, bus1.PASS, 32'(bus1.ERRCNT), bus1.FIRST_ERR_VLD,
                 32'(bus1.FIRST_ERR_ADDR), 32'(bus1.WORD_ADDR), bus1.ERRLOG_VLD, 32'(bus1.ERRLOG_ADDR));
`else
        cmp_inst(0, bus0.BUSY, bus0.DONE, bus0.PASS, 32'(bus0.ERRCNT), bus0.FIRST_ERR_VLD,
                 32'(bus0.FIRST_ERR_ADDR), 32'(bus0.WORD_ADDR), 1'b0, 32'd0);
        cmp_inst(1, bus1.BUSY, bus1.DONE, bus1.PASS, 32'(bus1.ERRCNT), bus1.FIRST_ERR_VLD,
                 32'(bus1.FIRST_ERR_ADDR), 32'(bus1.WORD_ADDR), 1'b0, 32'd0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge sysclk); #1;
    endtask

    task automatic start_pass(input logic [1:0] md);
        start = 1; mode = md; dvalid = 1; ddout = 1;   // bit in START cycle must be ignored
        cyc();
        start = 0; dvalid = 0; ddout = 0;
    endtask

    task automatic send_bit(input logic b);
        dvalid = 1; ddout = b;
        cyc();
        dvalid = 0;
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        for (int i = 15; i >= 0; i--) begin
            if (gap > 0) begin
                int n;
                n = $urandom_range(gap, 0);
                for (int g = 0; g < n; g++) begin ddout = 1'($urandom); cyc(); end
            end
            send_bit(w[i]);
        end
    endtask

    task automatic wait_done(input int k);
        for (int i = 0; i < 300; i++) begin
            if ((k == 0) ? bus0.DONE : bus1.DONE) break;
            cyc();
        end
        check($sformatf("i%0d_done_timeout", k), 32'((k == 0) ? bus0.DONE : bus1.DONE), 32'd1);
    endtask

    task automatic do_pop();
        pop = 1; cyc(); pop = 0;
    endtask

    initial begin
        rst_n = 1; start = 0; mode = 0; dvalid = 0; ddout = 0; pop = 0;
        #2 rst_n = 0;
        repeat (2) @(posedge sysclk);
        @(negedge sysclk); #2 rst_n = 1;
        cyc();
        check("rst_busy", 32'(bus0.BUSY), 0);
        check("rst_done", 32'(bus0.DONE), 0);

        // T2: all ones, back-to-back bits, DONE 65 cycles after first bit
        start_pass(2'b01);
        for (int i = 0; i < 64; i++) send_bit(1'b1);
        check("t2_done_early", 32'(bus0.DONE), 0);
        check("t2_busy_early", 32'(bus0.BUSY), 1);
        cyc();
        check("t2_done", 32'(bus0.DONE), 1);
        check("t2_busy", 32'(bus0.BUSY), 0);
        check("t2_pass", 32'(bus0.PASS), 1);
        check("t2_errcnt", 32'(bus0.ERRCNT), 0);
        check("t2_word_addr", 32'(bus0.WORD_ADDR), 3);
        send_bit(1'b0);
        check("t2_done_hold", 32'(bus0.DONE), 1);

        // T3: checkerboard, word 2 corrupted; without and with DVALID gaps
        for (int gap = 0; gap <= 3; gap += 3) begin
            start_pass(2'b10);
            send_word(16'hAAAA, gap);
            send_word(16'h5555, gap);
            send_word(16'hAAAB, gap);
            send_word(16'h5555, gap);
            wait_done(0);
            check("t3_errcnt", 32'(bus0.ERRCNT), 1);
            check("t3_first_vld", 32'(bus0.FIRST_ERR_VLD), 1);
            check("t3_first_addr", 32'(bus0.FIRST_ERR_ADDR), 2);
            check("t3_pass", 32'(bus0.PASS), 0);
        end

        // T4: address-in-data, words 1 and 3 corrupted
        start_pass(2'b11);
        send_word(16'h0000, 0);
        send_word(16'h0101, 0);
        send_word(16'h0002, 0);
        send_word(16'h0002, 0);
        wait_done(0);
        check("t4_errcnt", 32'(bus0.ERRCNT), 2);
        check("t4_first_addr", 32'(bus0.FIRST_ERR_ADDR), 1);
`ifdef ERR_LOG_EN
        check("t4_log_vld0", 32'(bus0.ERRLOG_VLD), 1);
        check("t4_log_addr0", 32'(bus0.ERRLOG_ADDR), 1);
        do_pop();
        check("t4_log_addr1", 32'(bus0.ERRLOG_ADDR), 3);
        do_pop();
        check("t4_log_empty", 32'(bus0.ERRLOG_VLD), 0);
`endif

        // T5: restart in the middle of word 1
        start_pass(2'b01);
        send_word(16'h0000, 0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        check("t5_errcnt_pre", 32'(bus0.ERRCNT), 1);
        check("t5_waddr_pre", 32'(bus0.WORD_ADDR), 1);
        start_pass(2'b01);
        check("t5_errcnt_clr", 32'(bus0.ERRCNT), 0);
        check("t5_waddr_clr", 32'(bus0.WORD_ADDR), 0);
        check("t5_first_clr", 32'(bus0.FIRST_ERR_VLD), 0);
        for (int w = 0; w < 4; w++) send_word(16'hFFFF, 0);
        wait_done(0);
        check("t5_pass", 32'(bus0.PASS), 1);

        // T6: 5 bad words, 2-bit counter saturates at 3
        start_pass(2'b00);
        for (int w = 0; w < 5; w++) send_word(16'hFFFF, 0);
        send_word(16'h0000, 0);
        wait_done(1);
        check("t6_errcnt_sat", 32'(bus1.ERRCNT), 3);
        check("t6_first_addr", 32'(bus1.FIRST_ERR_ADDR), 0);
        check("t6_pass", 32'(bus1.PASS), 0);
        check("t6_errcnt_i0", 32'(bus0.ERRCNT), 4);
`ifdef ERR_LOG_EN
        for (int j = 0; j < 4; j++) begin
            check($sformatf("t6_log%0d_vld", j), 32'(bus1.ERRLOG_VLD), 1);
            check($sformatf("t6_log%0d_addr", j), 32'(bus1.ERRLOG_ADDR), j);
            do_pop();
        end
        check("t6_log_empty", 32'(bus1.ERRLOG_VLD), 0);
`endif

        // T1: async reset in the middle of a pass with an error recorded
        start_pass(2'b00);
        send_word(16'hFFFF, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("t1_errcnt_pre", 32'(bus0.ERRCNT), 1);
        #2 rst_n = 0;
        #1;
        check("t1_busy", 32'(bus0.BUSY), 0);
        check("t1_errcnt", 32'(bus0.ERRCNT), 0);
        check("t1_first_vld", 32'(bus0.FIRST_ERR_VLD), 0);
        check("t1_word_addr", 32'(bus0.WORD_ADDR), 0);
        check("t1_busy_i1", 32'(bus1.BUSY), 0);
        @(negedge sysclk); #2 rst_n = 1;
        send_bit(1'b1);
        cyc();
        check("t1_idle_busy", 32'(bus0.BUSY), 0);
        check("t1_idle_done", 32'(bus0.DONE), 0);
        check("t1_idle_waddr", 32'(bus0.WORD_ADDR), 0);

        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
